// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle-core next-state engine.
//   - state_t   : StateID encoding consumed by the per-state control decoder
//   - OP_*      : IR[15:12] opcode values
//   - COND_*    : IR[1:0] condition encodings for ADD/NDU-family instructions
//   - cond_ok() : evaluates a condition field against the C/Z flags
package seq_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_ALU_EX   = 5'd2,
    S_WB_RC    = 5'd3,
    S_ADI_EX   = 5'd4,
    S_WB_RB    = 5'd5,
    S_NDU_EX   = 5'd6,
    S_LHI_WB   = 5'd7,
    S_MEM_ADDR = 5'd8,
    S_LW_MEM   = 5'd9,
    S_SW_MEM   = 5'd10,
    S_BEQ_CMP  = 5'd11,
    S_BEQ_TAKE = 5'd12,
    S_JAL      = 5'd13,
    S_JLR      = 5'd14,
    S_LSM_INIT = 5'd15,
    S_LM_STEP  = 5'd16,
    S_SM_STEP  = 5'd17,
    S_HALT     = 5'd31
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [1:0] COND_ALWAYS  = 2'b00;
  localparam logic [1:0] COND_Z       = 2'b01;
  localparam logic [1:0] COND_C       = 2'b10;
  localparam logic [1:0] COND_ILLEGAL = 2'b11;

  function automatic logic cond_ok(input logic [1:0] cond, input logic c, input logic z);
    return (cond == COND_ALWAYS) || ((cond == COND_C) && c) || ((cond == COND_Z) && z);
  endfunction

endpackage

// File: rtl/lsm_priority_enc.sv
// Lowest-set-bit finder for LM/SM register masks (purely combinational).
// Ports:
//   mask : register mask to search
//   idx  : index of the lowest set bit (0 when none is set)
//   none : 1 when mask is all zeros
module lsm_priority_enc #(
  parameter int MASK_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic              none
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx  = IDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Next-state engine for the multicycle core. Decodes the IR opcode and the
// C/Z/EQ flags, sequences multi-cycle instruction flows, stalls on memory
// ready and walks LM/SM register masks.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   IR                    : instruction register (opcode IR[15:12], cond IR[1:0])
//   carry_flag, zero_flag : C/Z flags, sampled in DECODE only
//   eq_flag               : ALU equality result, used in BEQ_CMP
//   mem_ready             : memory access completes this cycle
//   StateID               : current state (registered)
//   lsm_reg_idx           : register addressed by the current LM/SM step
//   instr_done            : one-cycle pulse on the first FETCH after any other state
//   skipped               : pulses with instr_done when a conditional op did not execute
//   halted                : sticky illegal-instruction flag
//   retire_cnt            : retired-instruction count
// Build option: define RETIRE_CNT_EN to implement a saturating retire counter;
// without it retire_cnt is tied to zero.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int MASK_W  = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        IR,
  input  logic               carry_flag,
  input  logic               zero_flag,
  input  logic               eq_flag,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] StateID,
  output logic [IDX_W-1:0]   lsm_reg_idx,
  output logic               instr_done,
  output logic               skipped,
  output logic               halted,
  output logic [15:0]        retire_cnt
);

  state_t              state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, skip_q, halt_q;
  logic                skip_d;

  logic [3:0]          opcode;
  logic [1:0]          cond;
  logic [MASK_W-1:0]   mask_clr;
  logic [MASK_W-1:0]   penc_in;
  logic [IDX_W-1:0]    penc_idx;
  logic                penc_none;
  logic                unused_ir;

  assign opcode    = IR[15:12];
  assign cond      = IR[1:0];
  assign unused_ir = ^IR[11:8];

  // Mask with the bit of the step currently being serviced removed.
  assign mask_clr = mask_q & ~(MASK_W'(1) << idx_q);

  // LSM_INIT searches the fresh IR mask; step states search what remains
  // after the current access completes.
  assign penc_in = (state_q == S_LSM_INIT) ? IR[MASK_W-1:0] : mask_clr;

  lsm_priority_enc #(
    .MASK_W (MASK_W),
    .IDX_W  (IDX_W)
  ) u_penc (
    .mask (penc_in),
    .idx  (penc_idx),
    .none (penc_none)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    skip_d  = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_NDU: begin
            if (cond == COND_ILLEGAL) begin
              state_d = S_HALT;
            end else if (cond_ok(cond, carry_flag, zero_flag)) begin
              state_d = (opcode == OP_ADD) ? S_ALU_EX : S_NDU_EX;
            end else begin
              state_d = S_FETCH;
              skip_d  = 1'b1;
            end
          end
          OP_ADI:        state_d = S_ADI_EX;
          OP_LHI:        state_d = S_LHI_WB;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_LM, OP_SM:  state_d = S_LSM_INIT;
          OP_BEQ:        state_d = S_BEQ_CMP;
          OP_JAL:        state_d = S_JAL;
          OP_JLR:        state_d = S_JLR;
          default:       state_d = S_HALT;
        endcase
      end
      S_ALU_EX, S_NDU_EX: state_d = S_WB_RC;
      S_ADI_EX:           state_d = S_WB_RB;
      S_WB_RC, S_WB_RB, S_LHI_WB, S_JAL, S_JLR, S_BEQ_TAKE: state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM, S_SW_MEM: if (mem_ready) state_d = S_FETCH;
      S_BEQ_CMP: state_d = eq_flag ? S_BEQ_TAKE : S_FETCH;
      S_LSM_INIT: begin
        mask_d = IR[MASK_W-1:0];
        if (penc_none) begin
          state_d = S_FETCH;
        end else begin
          idx_d   = penc_idx;
          state_d = (opcode == OP_LM) ? S_LM_STEP : S_SM_STEP;
        end
      end
      S_LM_STEP, S_SM_STEP: begin
        if (mem_ready) begin
          mask_d = mask_clr;
          if (penc_none) state_d = S_FETCH;
          else           idx_d   = penc_idx;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      mask_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      // HALT never reaches FETCH, so it can never raise instr_done.
      done_q  <= (state_d == S_FETCH) && (state_q != S_FETCH);
      skip_q  <= skip_d;
      halt_q  <= halt_q | (state_d == S_HALT);
    end
  end

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (done_q && !skip_q && (retire_q != 16'hFFFF)) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 16'd0;
`endif

  assign StateID     = STATE_W'(state_q);
  assign lsm_reg_idx = idx_q;
  assign instr_done  = done_q;
  assign skipped     = skip_q;
  assign halted      = halt_q;

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Next-state engine for the multicycle core; sits directly upstream of the per-state control decoder and drives its StateID input.
- Decodes the IR opcode and the C/Z/EQ flags, and sequences the multi-cycle instruction flows.
- Stalls on memory ready.
- Walks LM/SM register masks and supplies the current register index.

Parameters:
- STATE_W, 5, width of StateID.
- MASK_W, 8, LM/SM register mask width (IR[7:0]).
- IDX_W, 3, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- IR  in  16  instruction register (opcode IR[15:12], cond IR[1:0]).
- carry_flag  in  1  C flag.
- zero_flag  in  1  Z flag.
- eq_flag  in  1  ALU equality result for BEQ.
- mem_ready  in  1  memory access completes this cycle.
- StateID  out  STATE_W  current state, registered.
- lsm_reg_idx  out  IDX_W  register addressed by the current LM/SM step.
- instr_done  out  1  one-cycle pulse on return to FETCH.
- skipped  out  1  pulse with instr_done when a conditional instruction did not execute.
- halted  out  1  sticky illegal-instruction flag.
- retire_cnt  out  16  retired instruction count (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-high on reset.
  - Reset mid-operation aborts any flow.
  - Reset values: StateID=0 (FETCH), lsm_reg_idx=0, mask=0, instr_done=0, skipped=0, halted=0, retire_cnt=0.
- State encoding:
  - 0 FETCH, 1 DECODE, 2 ALU_EX, 3 WB_RC, 4 ADI_EX, 5 WB_RB, 6 NDU_EX, 7 LHI_WB, 8 MEM_ADDR, 9 LW_MEM, 10 SW_MEM.
  - 11 BEQ_CMP, 12 BEQ_TAKE, 13 JAL, 14 JLR, 15 LSM_INIT, 16 LM_STEP, 17 SM_STEP, 31 HALT.
- FETCH: holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: flags are sampled here only. Cond ok means IR[1:0] is 00, or 10 with carry_flag=1, or 01 with zero_flag=1. Branch by opcode:
  - 0000: cond ok → ALU_EX, else FETCH with skipped.
  - 0010: cond ok → NDU_EX, else FETCH with skipped.
  - 0000 or 0010 with IR[1:0]=11 → HALT.
  - 0001 → ADI_EX. 0011 → LHI_WB.
  - 0100 / 0101 → MEM_ADDR.
  - 0110 / 0111 → LSM_INIT.
  - 1100 → BEQ_CMP. 1000 → JAL. 1001 → JLR.
  - Any other opcode → HALT.
- Fixed-path transitions:
  - ALU_EX → WB_RC. NDU_EX → WB_RC. ADI_EX → WB_RB.
  - WB_RC, WB_RB, LHI_WB, JAL, JLR, BEQ_TAKE → FETCH.
  - MEM_ADDR → LW_MEM if opcode is 0100, else SW_MEM.
  - LW_MEM and SW_MEM hold until mem_ready=1, then → FETCH.
  - BEQ_CMP → BEQ_TAKE if eq_flag=1, else FETCH.
- LM/SM:
  - LSM_INIT latches mask=IR[7:0].
  - If mask=0 → FETCH (no access, not marked skipped).
  - Otherwise lsm_reg_idx = lowest set bit, then → LM_STEP (opcode 0110) or SM_STEP (0111).
  - In a step state, mem_ready=1 clears bit lsm_reg_idx. If the remaining mask is 0 → FETCH; else stay and load the next lowest set bit.
  - mem_ready=0 holds the state, index and mask unchanged.
  - Example: mask 0x81 takes 2 steps (idx 0, then 7). Mask 0xFF takes 8 steps in ascending order.
- HALT: absorbing until reset; halted=1 from the cycle HALT is entered.
- instr_done:
  - Registered pulse for exactly one cycle, coincident with the first FETCH cycle after any non-FETCH state.
  - The DECODE-to-FETCH skip path pulses both instr_done and skipped.
  - Never pulses on entry to HALT.
- IR is treated as stable from DECODE until the return to FETCH; the sequencer does not re-sample the opcode except in DECODE, MEM_ADDR and LSM_INIT.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined: retire_cnt increments on each instr_done pulse where skipped=0, saturating at 0xFFFF.
- Undefined: retire_cnt is constant 0 and no counter flops exist.

Decomposition:
- Shared package (seq_pkg):
  - State localparams.
  - Opcode constants: OP_ADD=0000, OP_ADI=0001, OP_NDU=0010, OP_LHI=0011, OP_LW=0100, OP_SW=0101, OP_LM=0110, OP_SM=0111, OP_JAL=1000, OP_JLR=1001, OP_BEQ=1100.
  - Cond encodings.
- One sub-module, lsm_priority_enc: combinational lowest-set-bit finder over MASK_W, outputs idx and a none flag.

Test Plan:
- ADD r1,r2,r3 (IR=0x0298), mem_ready=1 → StateID 0,1,2,3,0; instr_done pulses in the 5th cycle; skipped=0.
- ADC (IR[1:0]=10) with carry_flag=0 in DECODE → 0,1,0; instr_done=1 and skipped=1 together; retire_cnt unchanged.
- LW with mem_ready low for 3 cycles in LW_MEM → StateID holds at 9 for 4 cycles, then 0.
- LM mask 0x81, mem_ready=1 → LSM_INIT, then LM_STEP with idx 0, then LM_STEP with idx 7, then FETCH; mask 0x00 → LSM_INIT then FETCH.
- BEQ with eq_flag=1 → 1, 11, 12, 0; with eq_flag=0 → 1, 11, 0.
- Opcode 1111 → HALT(31), halted=1, stays there for 10 cycles; reset asserted mid-SM_STEP → StateID=0 asynchronously and all outputs at reset values.
